// File: rtl/press_meas.sv
// Pulse-width measurement behind the glitch filter: times each high pulse of i,
// emits a short/long classified event and a one-shot long-press notification.
module press_meas #(
    parameter int W       = 16,
    parameter int LONG_TH = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [W-1:0] evt_len,
    output logic         evt_long,
    output logic         lp_hit,
    output logic         drop,
    input  logic         clr_drop
);

    // state | meaning
    // IDLE  | level low, waiting for the next high sample
    // MEAS  | level high, cnt holds the high samples seen so far
    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TH      = W'(LONG_TH);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cnt_inc;
    logic         lp_nxt;
    logic         complete;
    logic         pop;
    logic         load;

    assign cnt_inc = cnt + ONE;
    assign pop     = evt_valid && evt_ready;
    assign load    = complete && (!evt_valid || evt_ready);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lp_nxt    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (i) begin
                    state_nxt = MEAS;
                    cnt_nxt   = ONE;
                    lp_nxt    = (TH == ONE);
                end
            end
            MEAS: begin
                if (i) begin
                    // Once saturated the count stops, so the threshold match cannot recur.
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt_inc;
                        lp_nxt  = (cnt_inc == TH);
                    end
                end else begin
                    complete  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lp_hit    <= 1'b0;
            evt_valid <= 1'b0;
            evt_len   <= '0;
            evt_long  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            lp_hit <= lp_nxt;

            if (load) begin
                evt_valid <= 1'b1;
                evt_len   <= cnt;
                evt_long  <= (cnt >= TH);
            end else if (pop) begin
                evt_valid <= 1'b0;
            end

            // A lost event in the same cycle as a clear keeps the flag set.
            if (complete && evt_valid && !evt_ready) begin
                drop <= 1'b1;
            end else if (clr_drop) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: doc/press_meas.md
# press_meas

Pulse-width measurement stage placed directly downstream of the 3-sample glitch filter. It consumes the filtered level and measures the length of every high pulse in clock cycles. Each completed pulse is emitted as a short/long classified event on a valid/ready interface. A one-cycle long-press notification fires while the level is still held high.

## Interface
Parameters:
- W, 16, width of the pulse-length counter and `evt_len`.
- LONG_TH, 1000, high-cycle count at or above which a pulse is classified long. Legal range is 1 to 2^W-1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- i  in  1  filtered level, the `y` of the upstream filter, synchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when `evt_valid && evt_ready` at a posedge.
- evt_len  out  W  measured high length in cycles, saturated.
- evt_long  out  1  `evt_len >= LONG_TH`.
- lp_hit  out  1  one-cycle pulse when the ongoing high reaches LONG_TH.
- drop  out  1  sticky flag: an event was lost because the output register was full.
- clr_drop  in  1  synchronous clear for `drop`.

## Operation
State machine with two states, IDLE and MEAS, plus a W-bit counter `cnt`.

- **IDLE**
  - `i==1` → go to MEAS, `cnt<=1`.
  - Otherwise stay in IDLE.
- **MEAS**
  - `i==1` → `cnt<=cnt+1`, saturating at 2^W-1 (no wrap).
  - `i==0` → completion: build an event with `len=cnt` and `long=(cnt>=LONG_TH)`, then go to IDLE.
  - Illegal or unused state encodings → IDLE.
- **lp_hit**
  - Registered.
  - Asserted for exactly one cycle after the posedge at which `cnt` becomes LONG_TH. This includes the IDLE→MEAS edge when LONG_TH=1.
  - Never asserted again within the same pulse, including while saturated.
- **Output register** (one entry: `evt_valid`, `evt_len`, `evt_long`)
  - On completion with the register empty, or with it being popped in the same cycle (`evt_valid && evt_ready`): load the new event; `evt_valid` is 1 next cycle.
  - On completion with `evt_valid && !evt_ready`: the new event is discarded, the held event is unchanged, and `drop<=1`.
  - Pop with no completion: `evt_valid<=0`. `evt_len` and `evt_long` hold their last values.
  - `evt_len` and `evt_long` are stable while `evt_valid && !evt_ready`.
- **drop**
  - Cleared by `clr_drop`.
  - If a set and `clr_drop` occur in the same cycle, the set wins.
- Pulses of any length ≥1 cycle are measured; nothing relies on the upstream 3-cycle minimum.

## Timing
- **Reset values:** `evt_valid=0`, `evt_len=0`, `evt_long=0`, `lp_hit=0`, `drop=0`, state=IDLE, `cnt=0`.
- **Asynchronous reset:** all outputs clear immediately on `rst_n` low. A reset mid-measurement discards the pulse and no event is produced.
- **After reset release:** if `i` is already 1, the first posedge starts a fresh measurement with `cnt=1`.
- **Measurement and event latency:** `i` high for N consecutive sampled edges, then low:
  - `cnt` reaches N at the Nth edge.
  - The event is loaded at edge N+1, the first low sample.
  - `evt_valid` is high from the cycle after that edge.
- **Back-to-back pulses:** one low sample separates pulses. The next high sample after completion starts a new measurement.
- **lp_hit latency:** high in the cycle following the LONG_TH-th consecutive high sample.
- **Saturation:** a saturated count reports `evt_len=2^W-1` and `evt_long=1`.

## Test plan
Use W=8 and LONG_TH=10 throughout.
1. **Reset:** assert `rst_n=0` mid-run → all outputs 0 asynchronously. Release with `i=0` → no event and no `lp_hit`.
2. **Short pulse:** `i=1` for 5 cycles then 0, `evt_ready=1` → `evt_valid` high for exactly 1 cycle, `evt_len=5`, `evt_long=0`, `lp_hit` never asserted.
3. **Long pulse:** `i=1` for 12 cycles → `lp_hit` high for 1 cycle after the 10th high sample. Event then has `evt_len=12`, `evt_long=1`.
4. **Saturation:** `i=1` for 300 cycles → `lp_hit` once, `evt_len=255`, `evt_long=1`.
5. **Backpressure:** `evt_ready=0`, pulses of 4 and 6 cycles separated by 1 low cycle → held event stays `evt_len=4` and `drop=1`. Then `evt_ready=1` for 1 cycle → pop, `evt_valid=0`. Then `clr_drop` → `drop=0`. Same-cycle check: a completion coinciding with a pop loads the new event with `evt_valid` staying 1.
6. **Reset mid-pulse:** after 7 high cycles, pulse `rst_n` low while `i` stays 1 → no event for the aborted pulse. After release, `i` falls 3 cycles later → event `evt_len=3`.
